csa_seq_arbiter: RTL and testbench

Shares one WIDTH-bit carry-skip adder datapath between NREQ requesters and sequences multi-word additions across it. Each requester streams an operation as a burst of WIDTH-bit beats; the block grants the adder to one requester per burst (round-robin), chains the carry from beat to beat, and returns registered sums with owner ID. It sits between the operand-producing engines and the carry-skip adder, which it owns exclusively.

---
 rtl/csa_pkg.sv | 12 +
 rtl/carry_skip_adder.sv | 43 ++++
 rtl/csa_seq_arbiter.sv | 168 ++++++++++++++++
 tb/tb_csa_seq_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-skip adder arbiter slice.
package csa_pkg;

  localparam int unsigned CSA_WIDTH = 16;
  localparam int unsigned CSA_GROUP = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/carry_skip_adder.sv
// Combinational carry-skip adder: bit propagate/generate, ripple inside each
// group, and a skip path that forwards the group carry-in when every bit of
// the group propagates.
module carry_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int GROUP = CSA_GROUP
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int NGRP = WIDTH / GROUP;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Ripple within each group, skip across groups whose bits all propagate.
  always_comb begin : p_add
    logic c_grp;
    logic c_bit;
    o_sum = '0;
    c_grp = i_cin;
    c_bit = 1'b0;
    for (int gi = 0; gi < NGRP; gi++) begin
      c_bit = c_grp;
      for (int bi = 0; bi < GROUP; bi++) begin
        o_sum[gi*GROUP+bi] = w_p[gi*GROUP+bi] ^ c_bit;
        c_bit = w_g[gi*GROUP+bi] | (w_p[gi*GROUP+bi] & c_bit);
      end
      c_grp = (&w_p[gi*GROUP +: GROUP]) ? c_grp : c_bit;
    end
    o_cout = c_grp;
  end

endmodule

// File: rtl/csa_seq_arbiter.sv
// Round-robin burst arbiter in front of one shared carry-skip adder.
// Chains the carry across the beats of a burst and registers each sum.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no owner; lowest-offset valid requester from rr_ptr wins now
// ST_LOCKED | r_owner holds the adder until its last beat is accepted
module csa_seq_arbiter
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int GROUP = CSA_GROUP,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_last,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic                  res_last,
  output logic [IDW-1:0]        res_id
);

  arb_state_e       r_state;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_carry;

  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_cout;
  logic             r_res_last;
  logic [IDW-1:0]   r_res_id;

  logic             w_pick_vld;
  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_own;
  logic [IDW-1:0]   w_next_ptr;
  logic             w_active;
  logic             w_stage_free;
  logic             w_vld;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin_req;
  logic             w_cin;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // Round-robin pick: scan offsets from the top down so the smallest offset
  // from rr_ptr is the one left standing.
  always_comb begin : p_pick
    int k;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    k          = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(r_rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      for (int r = 0; r < NREQ; r++) begin
        if (r == k && req_valid[r]) begin
          w_pick_vld = 1'b1;
          w_pick     = IDW'(r);
        end
      end
    end
  end

  // Owner select: in IDLE the grant is immediate, so the picked requester
  // drives the adder in the same cycle it wins.
  always_comb begin
    w_own        = (r_state == ST_IDLE) ? w_pick : r_owner;
    w_active     = (r_state == ST_LOCKED) | w_pick_vld;
    w_stage_free = ~r_res_valid | res_ready;
    w_vld        = 1'b0;
    w_a          = '0;
    w_b          = '0;
    w_cin_req    = 1'b0;
    w_last       = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (IDW'(r) == w_own) begin
        w_vld     = req_valid[r];
        w_a       = req_a[r*WIDTH +: WIDTH];
        w_b       = req_b[r*WIDTH +: WIDTH];
        w_cin_req = req_cin[r];
        w_last    = req_last[r];
      end
    end
    w_cin    = (r_state == ST_IDLE) ? w_cin_req : r_carry;
    w_accept = w_active & w_vld & w_stage_free;
  end

  // Only the owner is ever ready; held low while in reset.
  always_comb begin
    req_ready = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (IDW'(r) == w_own) req_ready[r] = rst_n & w_active & w_stage_free;
    end
  end

  assign w_next_ptr = (w_own == IDW'(NREQ - 1)) ? '0 : w_own + 1'b1;

  carry_skip_adder #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_adder (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Lock/carry bookkeeping: last beat releases the lock and advances rr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= w_next_ptr;
        r_carry  <= 1'b0;
      end else begin
        r_state  <= ST_LOCKED;
        r_owner  <= w_own;
        r_carry  <= w_cout;
      end
    end
  end

  // Output stage: load on accept, drain on res_ready, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_id    <= '0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum;
      r_res_cout  <= w_cout;
      r_res_last  <= w_last;
      r_res_id    <= w_own;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_last  = r_res_last;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_csa_seq_arbiter.sv
// Scoreboard bench for csa_seq_arbiter: directed bursts then random traffic.
module tb_csa_seq_arbiter;

  localparam int W   = 16;
  localparam int G   = 4;
  localparam int N   = 2;
  localparam int IDW = 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         last;
    int           gap;
  } beat_t;

  typedef struct {
    logic [W-1:0]   sum;
    logic           cout;
    logic           last;
    logic [IDW-1:0] id;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_cin = '0;
  logic [N-1:0]   req_last = '0;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [W-1:0]   res_sum;
  logic           res_cout;
  logic           res_last;
  logic [IDW-1:0] res_id;

  csa_seq_arbiter #(.WIDTH(W), .GROUP(G), .NREQ(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_last  (res_last),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  beat_t drv_q [N][$];
  res_t  sb_q[$];
  bit    armed [N];
  int    gap_cnt [N];
  int    force_stall = 0;
  int    rdy_pct = 100;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic push_beat(int r, logic [W-1:0] a, logic [W-1:0] b,
                           logic cin, logic last, int gap);
    beat_t bt;
    bt.a = a; bt.b = b; bt.cin = cin; bt.last = last; bt.gap = gap;
    drv_q[r].push_back(bt);
  endtask

  // One clock of stimulus: retire accepted beats, present the next ones.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (acc[r] && drv_q[r].size() > 0) begin
        void'(drv_q[r].pop_front());
        armed[r] = 1'b0;
      end
      if (!armed[r] && drv_q[r].size() > 0) begin
        armed[r]   = 1'b1;
        gap_cnt[r] = drv_q[r][0].gap;
      end
      if (armed[r] && gap_cnt[r] == 0) begin
        req_valid[r]       = 1'b1;
        req_a[r*W +: W]    = drv_q[r][0].a;
        req_b[r*W +: W]    = drv_q[r][0].b;
        req_cin[r]         = drv_q[r][0].cin;
        req_last[r]        = drv_q[r][0].last;
      end else begin
        req_valid[r]       = 1'b0;
        req_a[r*W +: W]    = W'($urandom);
        req_b[r*W +: W]    = W'($urandom);
        req_cin[r]         = 1'($urandom);
        req_last[r]        = 1'($urandom);
        if (armed[r]) gap_cnt[r]--;
      end
    end
    if (force_stall > 0) begin
      res_ready = 1'b0;
      force_stall--;
    end else begin
      res_ready = ($urandom_range(99) < rdy_pct);
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (sb_q.size() > 0) || res_valid;
    for (int r = 0; r < N; r++) if (drv_q[r].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 64'(n < budget), 64'd1);
  endtask

  // Monitor / reference model: arbitration rule, carry chain per burst,
  // result ordering, one-cycle latency and hold-under-backpressure.
  logic           m_locked;
  int             m_owner;
  int             m_ptr;
  logic           m_first [N];
  logic           m_carry [N];
  logic           m_lat_pend;
  logic           m_hold;
  logic [63:0]    m_hold_val;

  initial begin
    forever begin
      logic         stage_free;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] acc;
      bit           have;
      int           pick;
      res_t         e;
      logic [W:0]   full;
      logic         ci;
      @(negedge clk);
      if (!rst_n) begin
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;
        m_lat_pend = 1'b0; m_hold = 1'b0;
        for (int r = 0; r < N; r++) begin m_first[r] = 1'b1; m_carry[r] = 1'b0; end
        sb_q.delete();
        continue;
      end
      if (m_lat_pend) chk("latency_valid", 64'(res_valid), 64'd1);
      if (m_hold) chk("hold_stable", 64'({res_valid, res_sum, res_cout, res_last, res_id}), m_hold_val);
      stage_free = !res_valid || res_ready;
      have = 1'b0;
      pick = 0;
      if (m_locked) begin
        have = 1'b1;
        pick = m_owner;
      end else begin
        for (int i = N - 1; i >= 0; i--) begin
          int k;
          k = (m_ptr + i) % N;
          if (req_valid[k]) begin have = 1'b1; pick = k; end
        end
      end
      exp_rdy = '0;
      if (have && stage_free) exp_rdy[pick] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_spurious actual=valid required=no_pending_result");
        end else begin
          e = sb_q.pop_front();
          chk("res_sum", 64'(res_sum), 64'(e.sum));
          chk("res_cout", 64'(res_cout), 64'(e.cout));
          chk("res_last", 64'(res_last), 64'(e.last));
          chk("res_id", 64'(res_id), 64'(e.id));
        end
      end
      acc = req_valid & req_ready;
      m_lat_pend = (acc != '0);
      for (int r = 0; r < N; r++) begin
        if (acc[r]) begin
          ci     = m_first[r] ? req_cin[r] : m_carry[r];
          full   = {1'b0, req_a[r*W +: W]} + {1'b0, req_b[r*W +: W]} + {{W{1'b0}}, ci};
          e.sum  = full[W-1:0];
          e.cout = full[W];
          e.last = req_last[r];
          e.id   = IDW'(r);
          sb_q.push_back(e);
          if (req_last[r]) begin
            m_locked   = 1'b0;
            m_ptr      = (r + 1) % N;
            m_first[r] = 1'b1;
            m_carry[r] = 1'b0;
          end else begin
            m_locked   = 1'b1;
            m_owner    = r;
            m_first[r] = 1'b0;
            m_carry[r] = full[W];
          end
        end
      end
      m_hold     = res_valid && !res_ready;
      m_hold_val = 64'({res_valid, res_sum, res_cout, res_last, res_id});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < N; r++) begin armed[r] = 1'b0; gap_cnt[r] = 0; end

    // Reset values, with requests present during reset.
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_sum", 64'(res_sum), 64'd0);
    chk("rst_res_meta", 64'({res_cout, res_last, res_id}), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Single beat on r0.
    push_beat(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0);
    drain(200);

    // Three-beat carry chain on r1.
    push_beat(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    push_beat(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    push_beat(1, 16'h0001, 16'h0000, 1'b1, 1'b1, 0);
    drain(200);

    // Contention, twice, to see the pointer wrap.
    for (int rep = 0; rep < 2; rep++) begin
      for (int r = 0; r < N; r++) begin
        push_beat(r, 16'h8000 + 16'(r), 16'h8000, 1'b1, 1'b0, 0);
        push_beat(r, 16'h0010, 16'h0020 + 16'(rep), 1'b0, 1'b1, 0);
      end
      drain(200);
    end

    // Backpressure mid-burst.
    for (int i = 0; i < 4; i++)
      push_beat(0, 16'hFFFF, 16'h0001, 1'b0, (i == 3), 0);
    repeat (2) step();
    force_stall = 3;
    drain(200);

    // Owner stalls mid-burst while r1 waits.
    push_beat(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    push_beat(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 2);
    push_beat(0, 16'h1111, 16'h2222, 1'b0, 1'b1, 0);
    repeat (2) step();
    push_beat(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    drain(200);

    // Reset in the middle of a burst.
    push_beat(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    push_beat(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 0);
    push_beat(0, 16'h0005, 16'h0006, 1'b0, 1'b1, 0);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res_out", 64'({res_sum, res_cout, res_last, res_id}), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    for (int r = 0; r < N; r++) begin drv_q[r].delete(); armed[r] = 1'b0; end
    req_valid = '0;
    repeat (2) step();
    rst_n = 1'b1;
    push_beat(0, 16'h1234, 16'h0001, 1'b1, 1'b0, 0);
    push_beat(0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
    drain(200);

    // Random traffic with random gaps and backpressure.
    rdy_pct = 70;
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < N; r++) begin
        int nb;
        nb = $urandom_range(1, 3);
        for (int bu = 0; bu < nb; bu++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++) begin
            logic [W-1:0] ra;
            ra = ($urandom_range(2) == 0) ? 16'hFFFF : W'($urandom);
            push_beat(r, ra, W'($urandom), 1'($urandom), (i == len - 1),
                      ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0);
          end
        end
      end
      drain(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
